data_axi_bridge: RTL and testbench

//  Responder end of the core's data-side req/addr_ok/data_ok interface. Converts each accepted request into one

---
 rtl/data_axi_bridge_pkg.sv | 26 ++
 rtl/data_axi_bridge_if.sv | 69 ++++++
 rtl/data_axi_bridge_axi_single_issue.sv | 43 ++++
 rtl/data_axi_bridge.sv | 92 +++++++++
 tb/tb_data_axi_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_axi_bridge_pkg.sv
// Shared AXI encodings and the latched-request record for the data-side bridge.
package data_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  localparam logic [3:0] AXCACHE_CACHEABLE = 4'b1111;
  localparam logic [3:0] AXCACHE_DEVICE    = 4'b0000;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  cache;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } slot_t;

  function automatic logic [3:0] axcache_of(input logic cacheable);
    return cacheable ? AXCACHE_CACHEABLE : AXCACHE_DEVICE;
  endfunction

endpackage

// File: rtl/data_axi_bridge_if.sv
// Core data-port (req/addr_ok/data_ok) bundle and single-beat AXI3 master bundle.
interface data_req_if;
  logic        data_req;
  logic        data_cache;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [2:0]  data_size;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_cache, data_wr, data_wstrb, data_addr, data_size, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_cache, data_wr, data_wstrb, data_addr, data_size, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

interface data_axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/data_axi_bridge_axi_single_issue.sv
// Single request slot driving AR, or AW+W independently, until each channel handshakes.
// Latency: valids rise the cycle after issue. Backpressure: each valid holds until its ready.
// busy drops combinationally in the cycle the last outstanding channel handshakes.
module axi_single_issue
  import data_axi_bridge_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  issue,
  input  slot_t issue_slot,
  input  logic  arready,
  input  logic  awready,
  input  logic  wready,
  output slot_t slot,
  output logic  arvalid,
  output logic  awvalid,
  output logic  wvalid,
  output logic  busy
);

  logic ar_left, aw_left, w_left;

  assign ar_left = arvalid && !arready;
  assign aw_left = awvalid && !awready;
  assign w_left  = wvalid  && !wready;
  assign busy    = ar_left || aw_left || w_left;

  // issue is only granted when nothing is left over, so it may overwrite the flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      arvalid <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      slot    <= '0;
    end else begin
      arvalid <= issue ? !issue_slot.wr : ar_left;
      awvalid <= issue ?  issue_slot.wr : aw_left;
      wvalid  <= issue ?  issue_slot.wr : w_left;
      if (issue) slot <= issue_slot;
    end
  end

endmodule

// File: rtl/data_axi_bridge.sv
// Data-side responder: each accepted core request becomes one single-beat AXI3 read or write.
// Latency: accept at T, AXI valid at T+1, data_ok no earlier than T+2; completions in order.
// Backpressure: addr_ok withheld when OUTSTANDING in flight, slot busy, or read/write mix.
module data_axi_bridge
  import data_axi_bridge_pkg::*;
#(
  parameter int         OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID      = 4'd1
) (
  input  logic       clk,
  input  logic       resetn,
  data_req_if.slave  core,
  data_axi_if.master axi
);

  localparam int CW = $clog2(OUTSTANDING + 1);

  logic [CW-1:0] cnt;
  logic          cur_wr;
  logic          accept;
  logic          complete;
  logic          slot_busy;
  slot_t         req_slot;
  slot_t         slot;

  // never mixing directions in flight keeps read-after-write ordering trivial
  assign accept = resetn && core.data_req && (cnt < CW'(OUTSTANDING)) && !slot_busy
                  && (cnt == '0 || core.data_wr == cur_wr);

  // responses with nothing in flight are dropped
  assign complete = resetn && (cnt != '0)
                    && ((axi.rvalid && !cur_wr) || (axi.bvalid && cur_wr));

  assign req_slot = '{wr:    core.data_wr,
                      addr:  core.data_addr,
                      size:  core.data_size,
                      cache: axcache_of(core.data_cache),
                      wstrb: core.data_wstrb,
                      wdata: core.data_wdata};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt    <= '0;
      cur_wr <= 1'b0;
    end else begin
      cnt <= cnt + CW'(accept) - CW'(complete);
      if (accept && cnt == '0) cur_wr <= core.data_wr;
    end
  end

  axi_single_issue u_issue (
    .clk        (clk),
    .resetn     (resetn),
    .issue      (accept),
    .issue_slot (req_slot),
    .arready    (axi.arready),
    .awready    (axi.awready),
    .wready     (axi.wready),
    .slot       (slot),
    .arvalid    (axi.arvalid),
    .awvalid    (axi.awvalid),
    .wvalid     (axi.wvalid),
    .busy       (slot_busy)
  );

  assign core.data_addr_ok = accept;
  assign core.data_data_ok = complete;
  assign core.data_rdata   = axi.rdata;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = slot.addr;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = slot.size;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arcache = slot.cache;
  assign axi.rready  = 1'b1;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = slot.addr;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = slot.size;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awcache = slot.cache;
  assign axi.wdata   = slot.wdata;
  assign axi.wstrb   = slot.wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = 1'b1;

  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed scenarios followed by a randomized run, checked against a transaction-level model.
module tb_data_axi_bridge;

  localparam int OUTSTANDING = 2;

  logic clk = 1'b0;
  logic resetn;

  data_req_if core ();
  data_axi_if axi ();

  data_axi_bridge #(.OUTSTANDING(OUTSTANDING), .AXI_ID(4'd1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .core   (core),
    .axi    (axi)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        cache;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_m_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model: requests in flight, per-channel address phases, slave-side response queues
  int          m_cnt = 0;
  logic        m_cur_wr = 1'b0;
  logic        m_ar = 1'b0, m_aw = 1'b0, m_w = 1'b0, m_wresp = 1'b0;
  req_m_t      m_slot;
  req_m_t      q[$];
  logic [31:0] rq[$];
  int          bq = 0;
  logic [31:0] r_exp = '0;
  logic        last_acc = 1'b0, obs_aok = 1'b0, obs_dok = 1'b0;
  int          dok_seen = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        busy_now, e_aok, e_dok;
    req_m_t      r;
    logic [31:0] a;
    @(negedge clk);
    busy_now = (m_ar && !axi.arready) || (m_aw && !axi.awready) || (m_w && !axi.wready);
    e_aok = resetn && core.data_req && (m_cnt < OUTSTANDING) && !busy_now
            && (m_cnt == 0 || core.data_wr == m_cur_wr);
    e_dok = resetn && (m_cnt != 0)
            && ((axi.rvalid && !m_cur_wr) || (axi.bvalid && m_cur_wr));
    obs_aok = core.data_addr_ok;
    obs_dok = core.data_data_ok;
    chk1("addr_ok", core.data_addr_ok, e_aok);
    chk1("data_ok", core.data_data_ok, e_dok);
    chk1("arvalid", axi.arvalid, m_ar);
    chk1("awvalid", axi.awvalid, m_aw);
    chk1("wvalid", axi.wvalid, m_w);
    chk1("rready", axi.rready, 1'b1);
    chk1("bready", axi.bready, 1'b1);
    if (m_ar) begin
      chk("araddr", axi.araddr, m_slot.addr);
      chk("arsize", 32'(axi.arsize), 32'(m_slot.size));
      chk("arlen", 32'(axi.arlen), 32'd0);
      chk("arburst", 32'(axi.arburst), 32'd1);
      chk("arcache", 32'(axi.arcache), m_slot.cache ? 32'hF : 32'h0);
      chk("arid", 32'(axi.arid), 32'd1);
    end
    if (m_aw) begin
      chk("awaddr", axi.awaddr, m_slot.addr);
      chk("awsize", 32'(axi.awsize), 32'(m_slot.size));
      chk("awlen", 32'(axi.awlen), 32'd0);
      chk("awburst", 32'(axi.awburst), 32'd1);
      chk("awcache", 32'(axi.awcache), m_slot.cache ? 32'hF : 32'h0);
      chk("awid", 32'(axi.awid), 32'd1);
    end
    if (m_w) begin
      chk("wdata", axi.wdata, m_slot.wdata);
      chk("wstrb", 32'(axi.wstrb), 32'(m_slot.wstrb));
      chk1("wlast", axi.wlast, 1'b1);
    end
    if (e_dok && !m_cur_wr) chk("rdata", core.data_rdata, r_exp);
    if (core.data_data_ok) dok_seen++;
    last_acc = e_aok;
    if (!resetn) begin
      m_cnt = 0; m_ar = 0; m_aw = 0; m_w = 0; m_wresp = 0; bq = 0;
      q.delete(); rq.delete();
    end else begin
      if (m_ar && axi.arready) begin rq.push_back(m_slot.addr); m_ar = 0; end
      if (m_aw && axi.awready) m_aw = 0;
      if (m_w && axi.wready) m_w = 0;
      if (m_wresp && !m_aw && !m_w) begin bq++; m_wresp = 0; end
      if (axi.rvalid && rq.size() > 0) a = rq.pop_front();
      if (axi.bvalid && bq > 0) bq--;
      if (e_dok && q.size() > 0) r = q.pop_front();
      if (e_aok) begin
        r = '{core.data_wr, core.data_addr, core.data_size, core.data_cache,
              core.data_wstrb, core.data_wdata};
        q.push_back(r);
        m_slot = r;
        if (r.wr) begin m_aw = 1; m_w = 1; m_wresp = 1; end
        else m_ar = 1;
        if (m_cnt == 0) m_cur_wr = r.wr;
      end
      m_cnt = m_cnt + int'(e_aok) - int'(e_dok);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_axi();
    axi.arready = 0; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 0; axi.bvalid = 0; axi.rlast = 1;
    axi.rid = 4'd1; axi.bid = 4'd1; axi.rresp = 0; axi.bresp = 0; axi.rdata = '0;
  endtask

  task automatic set_req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic cache, input logic [3:0] wstrb, input logic [31:0] wdata);
    core.data_req = 1; core.data_wr = wr; core.data_addr = addr; core.data_size = size;
    core.data_cache = cache; core.data_wstrb = wstrb; core.data_wdata = wdata;
  endtask

  task automatic present_r();
    axi.rvalid = (rq.size() > 0);
    r_exp = (rq.size() > 0) ? mem(rq[0]) : 32'h0;
    axi.rdata = r_exp;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    core.data_req = 0;
    while (m_cnt != 0 && n < 60) begin
      axi.arready = 1; axi.awready = 1; axi.wready = 1;
      present_r();
      axi.bvalid = (bq > 0);
      step();
      n++;
    end
    idle_axi();
    chk(tag, 32'(dut.cnt), 32'd0);
  endtask

  task automatic drive_rand();
    if (!core.data_req || last_acc) begin
      core.data_req   = ($urandom_range(3) != 0);
      core.data_wr    = ($urandom_range(7) < 3);
      core.data_addr  = $urandom;
      core.data_size  = 3'($urandom_range(2));
      core.data_cache = 1'($urandom_range(1));
      core.data_wstrb = 4'($urandom);
      core.data_wdata = $urandom;
    end
    axi.arready = 1'($urandom_range(1));
    axi.awready = 1'($urandom_range(1));
    axi.wready  = 1'($urandom_range(1));
    axi.rvalid  = (rq.size() > 0) && ($urandom_range(1) == 1);
    r_exp       = (rq.size() > 0) ? mem(rq[0]) : 32'h0;
    axi.rdata   = axi.rvalid ? r_exp : $urandom;
    axi.rresp   = 2'($urandom);
    axi.bvalid  = (bq > 0) && ($urandom_range(1) == 1);
    axi.bresp   = 2'($urandom);
  endtask

  initial begin
    int d0;
    int n;
    resetn = 0;
    idle_axi();
    set_req(0, 32'h0000_1000, 3'd2, 0, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // reset state, with a request already pending
    step();
    chk("reset_cnt", 32'(dut.cnt), 32'd0);
    chk1("reset_aok", obs_aok, 1'b0);
    core.data_req = 0;
    resetn = 1;
    step();

    // scenario 1: single read
    d0 = dok_seen;
    set_req(0, 32'h1fc0_0000, 3'd2, 1, 4'h0, 32'h0);
    axi.arready = 1;
    step();
    core.data_req = 0;
    step();
    axi.arready = 0;
    step();
    step();
    axi.rvalid = 1; r_exp = 32'hDEAD_BEEF; axi.rdata = r_exp;
    step();
    axi.rvalid = 0;
    step();
    chk("t1_dok_count", 32'(dok_seen - d0), 32'd1);

    // scenario 2: write with AW and W completing separately
    d0 = dok_seen;
    set_req(1, 32'h0000_0010, 3'd1, 0, 4'b0011, 32'hCAFE_F00D);
    step();
    core.data_req = 0; axi.awready = 1;
    step();
    axi.awready = 0;
    step();
    step();
    axi.wready = 1;
    step();
    axi.wready = 0;
    step();
    axi.bvalid = 1;
    step();
    axi.bvalid = 0;
    step();
    chk("t2_dok_count", 32'(dok_seen - d0), 32'd1);

    // scenarios 3 and 5: two reads in flight, third blocked, accept alongside completion
    d0 = dok_seen;
    axi.arready = 1;
    set_req(0, 32'h0000_0100, 3'd2, 0, 4'h0, 32'h0);
    step();
    set_req(0, 32'h0000_0104, 3'd2, 0, 4'h0, 32'h0);
    step();
    set_req(0, 32'h0000_0108, 3'd0, 1, 4'h0, 32'h0);
    step();
    chk1("t3_third_blocked", obs_aok, 1'b0);
    present_r();
    step();
    present_r();
    step();
    chk1("t5_accept_with_cpl", obs_aok, 1'b1);
    chk1("t5_dok", obs_dok, 1'b1);
    chk("t5_cnt", 32'(dut.cnt), 32'd1);
    core.data_req = 0; axi.rvalid = 0;
    drain("t3_drain");
    chk("t3_dok_count", 32'(dok_seen - d0), 32'd3);

    // scenario 4: read waits behind an outstanding write
    set_req(1, 32'h0000_0200, 3'd2, 1, 4'hF, 32'h1234_5678);
    axi.awready = 1; axi.wready = 1;
    step();
    core.data_req = 0;
    step();
    idle_axi();
    set_req(0, 32'h0000_0300, 3'd2, 0, 4'h0, 32'h0);
    step();
    chk1("t4_read_blocked", obs_aok, 1'b0);
    axi.bvalid = 1;
    step();
    chk1("t4_write_dok", obs_dok, 1'b1);
    axi.bvalid = 0;
    n = 0;
    while (!last_acc && n < 3) begin step(); n++; end
    chk1("t4_read_accepted", obs_aok, 1'b1);
    drain("t4_drain");

    // stray responses with nothing in flight are dropped
    axi.rvalid = 1; axi.bvalid = 1; axi.rdata = 32'h0BAD_0BAD;
    step();
    chk1("stray_dok", obs_dok, 1'b0);
    idle_axi();

    // scenario 6: reset with arvalid high and two reads in flight
    axi.arready = 1;
    set_req(0, 32'h0000_0400, 3'd2, 0, 4'h0, 32'h0);
    step();
    set_req(0, 32'h0000_0404, 3'd2, 0, 4'h0, 32'h0);
    step();
    core.data_req = 0; axi.arready = 0;
    step();
    chk("t6_cnt_before", 32'(dut.cnt), 32'd2);
    resetn = 0;
    step();
    step();
    chk("t6_cnt_after", 32'(dut.cnt), 32'd0);
    chk1("t6_arvalid_after", axi.arvalid, 1'b0);
    resetn = 1;
    set_req(0, 32'h0000_0500, 3'd2, 0, 4'h0, 32'h0);
    axi.arready = 1;
    step();
    chk1("t6_aok_after_release", obs_aok, 1'b1);
    drain("t6_drain");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step();
    end
    drain("final_drain");
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
